// File: rtl/alu_operand_stage.sv
// Operand-fetch stage in front of the 16-bit ALU: register file, two-cycle single-port
// operand read (Rn then Rm), B shifter / source selects and a registered valid/ready output.
module alu_operand_stage #(
  parameter int unsigned DW   = 16,
  parameter int unsigned NREG = 8,
  localparam int unsigned AW  = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [AW-1:0] req_rn,
  input  logic [AW-1:0] req_rm,
  input  logic [1:0]    req_shift,
  input  logic          req_asel,
  input  logic          req_bsel,
  input  logic [4:0]    req_imm5,
  input  logic [1:0]    req_aluop,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] Ain,
  output logic [DW-1:0] Bin,
  output logic [1:0]    ALUop
);

  typedef enum logic [1:0] {StIdle, StReadA, StReadB, StHold} state_e;

  state_e state_q, state_d;

  logic [DW-1:0] rf_q [NREG];
  logic [DW-1:0] rf_d [NREG];

  logic [AW-1:0] rn_q, rn_d, rm_q, rm_d;
  logic [1:0]    shift_q, shift_d, aluop_q, aluop_d;
  logic          asel_q, asel_d, bsel_q, bsel_d;
  logic [4:0]    imm5_q, imm5_d;
  logic [DW-1:0] a_reg_q, a_reg_d;
  logic [DW-1:0] ain_q, ain_d, bin_q, bin_d;
  logic [1:0]    alu_op_q, alu_op_d;
  logic          out_valid_q, out_valid_d;

  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic [DW-1:0] shifted;

  // Reads index the post-write view so a same-edge write is seen (write-first).
  always_comb begin
    rf_d = rf_q;
    if (wr_en) rf_d[wr_addr] = wr_data;
  end

  assign rd_addr = (state_q == StReadA) ? rn_q : rm_q;
  assign rd_data = rf_d[rd_addr];

  always_comb begin
    unique case (shift_q)
      2'b01:   shifted = {rd_data[DW-2:0], 1'b0};
      2'b10:   shifted = {1'b0, rd_data[DW-1:1]};
      2'b11:   shifted = {rd_data[DW-1], rd_data[DW-1:1]};
      default: shifted = rd_data;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= StIdle;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (req_valid) state_d = StReadA;
      StReadA: state_d = StReadB;
      StReadB: state_d = StHold;
      StHold:  if (out_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Moore outputs
  always_comb begin
    req_ready = (state_q == StIdle);
  end

  // Datapath next-state
  always_comb begin
    rn_d        = rn_q;
    rm_d        = rm_q;
    shift_d     = shift_q;
    asel_d      = asel_q;
    bsel_d      = bsel_q;
    imm5_d      = imm5_q;
    aluop_d     = aluop_q;
    a_reg_d     = a_reg_q;
    ain_d       = ain_q;
    bin_d       = bin_q;
    alu_op_d    = alu_op_q;
    out_valid_d = out_valid_q;
    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          rn_d    = req_rn;
          rm_d    = req_rm;
          shift_d = req_shift;
          asel_d  = req_asel;
          bsel_d  = req_bsel;
          imm5_d  = req_imm5;
          aluop_d = req_aluop;
        end
      end
      StReadA: a_reg_d = rd_data;
      StReadB: begin
        ain_d       = asel_q ? '0 : a_reg_q;
        bin_d       = bsel_q ? {{(DW-5){1'b0}}, imm5_q} : shifted;
        alu_op_d    = aluop_q;
        out_valid_d = 1'b1;
      end
      StHold: if (out_ready) out_valid_d = 1'b0;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(NREG); i++) rf_q[i] <= '0;
      rn_q        <= '0;
      rm_q        <= '0;
      shift_q     <= '0;
      asel_q      <= 1'b0;
      bsel_q      <= 1'b0;
      imm5_q      <= '0;
      aluop_q     <= '0;
      a_reg_q     <= '0;
      ain_q       <= '0;
      bin_q       <= '0;
      alu_op_q    <= '0;
      out_valid_q <= 1'b0;
    end else begin
      rf_q        <= rf_d;
      rn_q        <= rn_d;
      rm_q        <= rm_d;
      shift_q     <= shift_d;
      asel_q      <= asel_d;
      bsel_q      <= bsel_d;
      imm5_q      <= imm5_d;
      aluop_q     <= aluop_d;
      a_reg_q     <= a_reg_d;
      ain_q       <= ain_d;
      bin_q       <= bin_d;
      alu_op_q    <= alu_op_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_valid = out_valid_q;
  assign Ain       = ain_q;
  assign Bin       = bin_q;
  assign ALUop     = alu_op_q;

endmodule
